conv_mac_sequencer: RTL and testbench

// - Driver and collector for the external two-product multiply-add primitive (p = a0*b0 + a1*b1, fixed pipeline latency).
// - Accepts one pixel/weight pair per handshake beat and packs two pairs per multadd issue.
// - Tracks the multadd pipeline latency and accumulates partial sums over one kernel window.
// - Emits one sum per TAPS pairs through a valid/ready output to the conv result path.

---
 rtl/conv_mac_sequencer_pkg.sv | 39 +++
 rtl/conv_mac_tag_pipe.sv | 33 +++
 rtl/conv_mac_sequencer.sv | 174 +++++++++++++++++
 tb/tb_conv_mac_sequencer.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_mac_sequencer_pkg.sv
// Shared definitions for the conv MAC sequencer: pack FSM states, pipeline tag
// type, default geometry constants and a constant-foldable ceil(log2()).
package conv_mac_sequencer_pkg;

    localparam int unsigned DEF_ASIZE  = 8;
    localparam int unsigned DEF_BSIZE  = 8;
    localparam int unsigned DEF_TAPS   = 9;
    localparam int unsigned DEF_MA_LAT = 3;
    localparam int unsigned DEF_ACC_W  = 20;

    // Pair packing: EMPTY waits for operand pair 0, HALF holds pair 0 and
    // waits for pair 1.
    typedef enum logic {
        EMPTY,
        HALF
    } pack_state_t;

    // Tag travelling alongside each multadd issue.
    typedef struct packed {
        logic vld;
        logic last;
    } tag_t;

    // Number of bits needed to encode values 0..value-1 (0 for value <= 1).
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned v;
        int unsigned r;
        r = 0;
        v = (value > 0) ? value - 1 : 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (v != 0) begin
                r = r + 1;
                v = v >> 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/conv_mac_tag_pipe.sv
// MA_LAT-deep shift register of {vld,last} tags that mirrors the external
// multadd pipeline; it advances only when the multadd clock enable is high.
module conv_mac_tag_pipe
    import conv_mac_sequencer_pkg::*;
#(
    parameter int unsigned MA_LAT = DEF_MA_LAT
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  tag_t tag_in,
    output tag_t tag_out
);

    tag_t stage [MA_LAT];

    // Shift tags one stage per enabled cycle; reset drops every in-flight tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < MA_LAT; i++) begin
                stage[i] <= '0;
            end
        end else if (en) begin
            stage[0] <= tag_in;
            for (int unsigned i = 1; i < MA_LAT; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tag_out = stage[MA_LAT-1];

endmodule

// File: rtl/conv_mac_sequencer.sv
// Driver/collector for an external two-product multadd (p = a0*b0 + a1*b1).
// Packs two pixel/weight pairs per issue, follows the multadd latency with a
// tag pipe, accumulates one kernel window and presents the sum via valid/ready.
module conv_mac_sequencer
    import conv_mac_sequencer_pkg::*;
#(
    parameter int unsigned ASIZE  = DEF_ASIZE,
    parameter int unsigned BSIZE  = DEF_BSIZE,
    parameter int unsigned PSIZE  = ASIZE + BSIZE + 1,
    parameter int unsigned TAPS   = DEF_TAPS,
    parameter int unsigned MA_LAT = DEF_MA_LAT,
    parameter int unsigned ACC_W  = DEF_ACC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ASIZE-1:0] in_a,
    input  logic [BSIZE-1:0] in_b,
    output logic             ma_ce,
    output logic [ASIZE-1:0] ma_a0,
    output logic [BSIZE-1:0] ma_b0,
    output logic [ASIZE-1:0] ma_a1,
    output logic [BSIZE-1:0] ma_b1,
    input  logic [PSIZE-1:0] ma_p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum
);

    localparam int unsigned CNT_W = clog2(TAPS + 1);

    pack_state_t      state;
    pack_state_t      state_next;
    logic [CNT_W-1:0] tap_cnt;
    logic [CNT_W-1:0] tap_next;
    logic [CNT_W-1:0] tap_inc;
    logic             at_end;

    logic             stall;
    logic             accept;
    logic             issue;
    logic             issue_pad;
    logic             issue_last;
    logic             hold_load;

    logic [ASIZE-1:0] hold_a;
    logic [BSIZE-1:0] hold_b;

    tag_t             issue_tag;
    tag_t             exit_tag;

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] p_ext;

    // A pending output that downstream refuses freezes the whole datapath,
    // including the external multadd, so products stay aligned with tags.
    assign stall    = out_valid && !out_ready;
    assign ma_ce    = !stall;
    assign in_ready = !rst && !stall;
    assign accept   = in_valid && in_ready;

    assign tap_inc  = tap_cnt + CNT_W'(1);
    assign at_end   = (tap_inc == CNT_W'(TAPS));
    assign p_ext    = ACC_W'(ma_p);

    // Pack FSM state and window tap counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= EMPTY;
            tap_cnt <= '0;
        end else begin
            state   <= state_next;
            tap_cnt <= tap_next;
        end
    end

    // Decide whether an accepted pair is parked or completes an issue.
    always_comb begin
        state_next = state;
        tap_next   = tap_cnt;
        issue      = 1'b0;
        issue_pad  = 1'b0;
        issue_last = 1'b0;
        hold_load  = 1'b0;
        if (accept) begin
            case (state)
                EMPTY: begin
                    if (at_end) begin
                        // Odd window: lone final pair issues with a zero partner.
                        issue      = 1'b1;
                        issue_pad  = 1'b1;
                        issue_last = 1'b1;
                        tap_next   = '0;
                    end else begin
                        hold_load  = 1'b1;
                        tap_next   = tap_inc;
                        state_next = HALF;
                    end
                end
                HALF: begin
                    issue      = 1'b1;
                    issue_last = at_end;
                    tap_next   = at_end ? '0 : tap_inc;
                    state_next = EMPTY;
                end
                default: begin
                    state_next = EMPTY;
                end
            endcase
        end
    end

    // Operand registers and the tag for the operands currently presented.
    // The multadd samples the operands one cycle after they load, so this tag
    // register stands in front of the MA_LAT-deep pipe to keep alignment.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_a    <= '0;
            hold_b    <= '0;
            ma_a0     <= '0;
            ma_b0     <= '0;
            ma_a1     <= '0;
            ma_b1     <= '0;
            issue_tag <= '0;
        end else if (!stall) begin
            if (hold_load) begin
                hold_a <= in_a;
                hold_b <= in_b;
            end
            if (issue) begin
                ma_a0 <= issue_pad ? in_a : hold_a;
                ma_b0 <= issue_pad ? in_b : hold_b;
                ma_a1 <= issue_pad ? '0   : in_a;
                ma_b1 <= issue_pad ? '0   : in_b;
            end
            issue_tag.vld  <= issue;
            issue_tag.last <= issue_last;
        end
    end

    conv_mac_tag_pipe #(
        .MA_LAT (MA_LAT)
    ) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .en      (ma_ce),
        .tag_in  (issue_tag),
        .tag_out (exit_tag)
    );

    // Accumulate tagged products; the last one of a window moves to the output.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            out_sum   <= '0;
            out_valid <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (!stall && exit_tag.vld) begin
                if (exit_tag.last) begin
                    out_sum   <= acc + p_ext;
                    out_valid <= 1'b1;
                    acc       <= '0;
                end else begin
                    acc <= acc + p_ext;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_mac_sequencer.sv
// Self-checking bench for conv_mac_sequencer with a behavioural ce-gated
// multadd (latency 3). Two instances: TAPS=9 (main) and TAPS=4.
module tb_conv_mac_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // ---------------- TAPS=9 instance ----------------
    logic        in_valid, in_ready, ma_ce, out_valid, out_ready;
    logic [7:0]  in_a, in_b, ma_a0, ma_b0, ma_a1, ma_b1;
    logic [16:0] ma_p, m0, m1;
    logic [19:0] out_sum;

    conv_mac_sequencer #(
        .ASIZE (8), .BSIZE (8), .PSIZE (17), .TAPS (9), .MA_LAT (3), .ACC_W (20)
    ) dut (
        .clk (clk), .rst (rst), .in_valid (in_valid), .in_ready (in_ready),
        .in_a (in_a), .in_b (in_b), .ma_ce (ma_ce), .ma_a0 (ma_a0), .ma_b0 (ma_b0),
        .ma_a1 (ma_a1), .ma_b1 (ma_b1), .ma_p (ma_p), .out_valid (out_valid),
        .out_ready (out_ready), .out_sum (out_sum)
    );

    // ---------------- TAPS=4 instance ----------------
    logic        in_valid4, in_ready4, ma_ce4, out_valid4, out_ready4;
    logic [7:0]  in_a4, in_b4, ma_a04, ma_b04, ma_a14, ma_b14;
    logic [16:0] ma_p4, n0, n1;
    logic [19:0] out_sum4;

    conv_mac_sequencer #(
        .ASIZE (8), .BSIZE (8), .PSIZE (17), .TAPS (4), .MA_LAT (3), .ACC_W (20)
    ) dut4 (
        .clk (clk), .rst (rst), .in_valid (in_valid4), .in_ready (in_ready4),
        .in_a (in_a4), .in_b (in_b4), .ma_ce (ma_ce4), .ma_a0 (ma_a04), .ma_b0 (ma_b04),
        .ma_a1 (ma_a14), .ma_b1 (ma_b14), .ma_p (ma_p4), .out_valid (out_valid4),
        .out_ready (out_ready4), .out_sum (out_sum4)
    );

    // Behavioural multadd models: three ce-gated stages, reset on the shared rst.
    always @(posedge clk) begin
        if (rst) begin
            m0 <= '0; m1 <= '0; ma_p <= '0;
        end else if (ma_ce) begin
            m0   <= 17'(ma_a0) * 17'(ma_b0) + 17'(ma_a1) * 17'(ma_b1);
            m1   <= m0;
            ma_p <= m1;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            n0 <= '0; n1 <= '0; ma_p4 <= '0;
        end else if (ma_ce4) begin
            n0    <= 17'(ma_a04) * 17'(ma_b04) + 17'(ma_a14) * 17'(ma_b14);
            n1    <= n0;
            ma_p4 <= n1;
        end
    end

    // Observers: cycle stamps, delivered sums, operand-tuple changes (issues).
    int   cyc = 0;
    int   acc_last = 0;
    int   rise_cyc = 0;
    logic ov_prev = 1'b0;
    int   got[$];
    int   got4[$];
    int   chg = 0;
    int   chg4 = 0;
    logic [31:0] ops_prev = '0;
    logic [31:0] ops_prev4 = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && in_valid && in_ready) acc_last <= cyc;
        if (!rst && out_valid && !ov_prev) rise_cyc <= cyc;
        ov_prev <= out_valid;
        if (!rst && out_valid && out_ready) got.push_back(int'(out_sum));
        if (!rst && out_valid4 && out_ready4) got4.push_back(int'(out_sum4));
        if ({ma_a0, ma_b0, ma_a1, ma_b1} != ops_prev) chg <= chg + 1;
        ops_prev <= {ma_a0, ma_b0, ma_a1, ma_b1};
        if ({ma_a04, ma_b04, ma_a14, ma_b14} != ops_prev4) chg4 <= chg4 + 1;
        ops_prev4 <= {ma_a04, ma_b04, ma_a14, ma_b14};
    end

    logic rand_ready = 1'b0;
    logic not_ready_seen = 1'b0;

    // Offer one pair to the TAPS=9 instance until accepted (bounded).
    task automatic send(input logic [7:0] a, input logic [7:0] b);
        logic rdy;
        int   tries;
        tries = 0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        do begin
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
            #1;
            rdy = in_ready;
            if (!rdy) not_ready_seen = 1'b1;
            @(posedge clk);
            #1;
            tries++;
        end while (!rdy && tries < 200);
        if (!rdy) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready=%0b required=1", in_ready);
        end
    endtask

    task automatic send4(input logic [7:0] a, input logic [7:0] b);
        logic rdy;
        int   tries;
        tries = 0;
        in_valid4 = 1'b1;
        in_a4 = a;
        in_b4 = b;
        do begin
            rdy = in_ready4;
            @(posedge clk);
            #1;
            tries++;
        end while (!rdy && tries < 200);
        if (!rdy) begin
            checks++; errors++;
            $display("FAIL send4_timeout: in_ready=%0b required=1", in_ready4);
        end
        in_valid4 = 1'b0;
    endtask

    task automatic wait_sums(input int n);
        int t;
        t = 0;
        while (got.size() < n && t < 150) begin
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
            t++;
        end
        if (got.size() < n) begin
            checks++; errors++;
            $display("FAIL sum_timeout: got %0d sums required %0d", got.size(), n);
        end
    endtask

    // Compare delivered sums against the model's expected list.
    task automatic compare_sums(input string name, input int expv[$]);
        for (int i = 0; i < expv.size(); i++) begin
            checks++;
            if (i >= got.size()) begin
                errors++;
                $display("FAIL %s[%0d]: missing sum required %0d", name, i, expv[i]);
            end else if (got[i] !== expv[i]) begin
                errors++;
                $display("FAIL %s[%0d]: got %0d required %0d", name, i, got[i], expv[i]);
            end
        end
    endtask

    // Reference: sum of products of a window, modulo 2^20.
    function automatic int window_sum(input int a[$], input int b[$]);
        longint s;
        s = 0;
        for (int i = 0; i < a.size(); i++) s += longint'(a[i]) * longint'(b[i]);
        return int'(s % (64'd1 << 20));
    endfunction

    task automatic check_reset_values(input string name);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL %s_in_ready: got %b required 0", name, in_ready); end
        checks++;
        if (ma_ce !== 1'b1) begin errors++; $display("FAIL %s_ma_ce: got %b required 1", name, ma_ce); end
        checks++;
        if ({ma_a0, ma_b0, ma_a1, ma_b1} !== 32'h0) begin
            errors++; $display("FAIL %s_operands: got %h required 0", name, {ma_a0, ma_b0, ma_a1, ma_b1});
        end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_out_valid: got %b required 0", name, out_valid); end
        checks++;
        if (out_sum !== 20'h0) begin errors++; $display("FAIL %s_out_sum: got %0d required 0", name, out_sum); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        checks++;
        if (out_valid4 !== 1'b0 || in_ready4 !== 1'b0) begin
            errors++; $display("FAIL reset_dut4: valid=%b ready=%b required 0 0", out_valid4, in_ready4);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b required 1", in_ready); end
    endtask

    task automatic test_ones();
        int a[$], b[$], expv[$];
        got.delete();
        for (int i = 0; i < 9; i++) begin a.push_back(1); b.push_back(1); send(8'd1, 8'd1); end
        in_valid = 1'b0;
        checks++;
        if ({ma_a0, ma_b0, ma_a1, ma_b1} !== {8'd1, 8'd1, 8'd0, 8'd0}) begin
            errors++; $display("FAIL ones_padding: got %h required 01010000", {ma_a0, ma_b0, ma_a1, ma_b1});
        end
        wait_sums(1);
        expv.push_back(window_sum(a, b));
        compare_sums("ones_sum", expv);
        checks++;
        if (rise_cyc - acc_last !== 5) begin
            errors++; $display("FAIL ones_latency: got %0d cycles required 5", rise_cyc - acc_last);
        end
    endtask

    task automatic test_max();
        int expv[$];
        got.delete();
        for (int i = 0; i < 9; i++) send(8'd255, 8'd255);
        in_valid = 1'b0;
        wait_sums(1);
        expv.push_back(585225);
        compare_sums("max_sum", expv);
    endtask

    task automatic test_back_to_back();
        int a1[$], a2[$], b[$], expv[$];
        int chg0;
        got.delete();
        not_ready_seen = 1'b0;
        chg0 = chg;
        for (int k = 1; k <= 9; k++) begin a1.push_back(k); a2.push_back(2 * k); b.push_back(1); end
        for (int k = 0; k < 9; k++) send(8'(a1[k]), 8'd1);
        for (int k = 0; k < 9; k++) send(8'(a2[k]), 8'd1);
        in_valid = 1'b0;
        checks++;
        if (not_ready_seen !== 1'b0) begin errors++; $display("FAIL b2b_in_ready: dropped=%b required 0", not_ready_seen); end
        wait_sums(2);
        expv.push_back(window_sum(a1, b));
        expv.push_back(window_sum(a2, b));
        compare_sums("b2b_sum", expv);
        checks++;
        if (chg - chg0 !== 10) begin errors++; $display("FAIL b2b_issues: got %0d required 10", chg - chg0); end
    endtask

    task automatic test_stall();
        int expv[$];
        got.delete();
        out_ready = 1'b0;
        for (int k = 1; k <= 9; k++) send(8'(k), 8'd1);
        fork
            begin
                for (int k = 1; k <= 9; k++) send(8'(2 * k), 8'd1);
                in_valid = 1'b0;
            end
            begin
                int t;
                logic [31:0] ops;
                t = 0;
                while (!out_valid && t < 60) begin @(posedge clk); #1; t++; end
                checks++;
                if (!out_valid) begin errors++; $display("FAIL stall_wait: out_valid=%b required 1", out_valid); end
                #2;
                ops = {ma_a0, ma_b0, ma_a1, ma_b1};
                for (int c = 0; c < 4; c++) begin
                    checks++;
                    if (in_ready !== 1'b0 || ma_ce !== 1'b0) begin
                        errors++; $display("FAIL stall_ctrl: in_ready=%b ma_ce=%b required 0 0", in_ready, ma_ce);
                    end
                    checks++;
                    if (out_sum !== 20'd45 || {ma_a0, ma_b0, ma_a1, ma_b1} !== ops) begin
                        errors++; $display("FAIL stall_hold: out_sum=%0d required 45", out_sum);
                    end
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        wait_sums(2);
        expv.push_back(45);
        expv.push_back(90);
        compare_sums("stall_sum", expv);
    endtask

    task automatic test_taps4();
        int a[$], b[$];
        int chg0, expv, t;
        a = '{2, 4, 6, 8};
        b = '{3, 5, 7, 9};
        chg0 = chg4;
        got4.delete();
        for (int i = 0; i < 4; i++) send4(8'(a[i]), 8'(b[i]));
        checks++;
        if ({ma_a04, ma_b04, ma_a14, ma_b14} !== {8'd6, 8'd7, 8'd8, 8'd9}) begin
            errors++; $display("FAIL taps4_operands: got %h required 06070809", {ma_a04, ma_b04, ma_a14, ma_b14});
        end
        t = 0;
        while (got4.size() < 1 && t < 50) begin @(posedge clk); #1; t++; end
        expv = window_sum(a, b);
        checks++;
        if (got4.size() < 1) begin
            errors++; $display("FAIL taps4_sum: no sum required %0d", expv);
        end else if (got4[0] !== expv) begin
            errors++; $display("FAIL taps4_sum: got %0d required %0d", got4[0], expv);
        end
        checks++;
        if (chg4 - chg0 !== 2) begin errors++; $display("FAIL taps4_issues: got %0d required 2", chg4 - chg0); end
    endtask

    task automatic test_reset_mid();
        int expv[$];
        logic seen;
        got.delete();
        for (int i = 0; i < 5; i++) send(8'd1, 8'd1);
        in_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("midreset");
        rst = 1'b0;
        seen = 1'b0;
        repeat (12) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
        checks++;
        if (seen !== 1'b0 || got.size() !== 0) begin
            errors++; $display("FAIL midreset_no_valid: seen=%b sums=%0d required 0 0", seen, got.size());
        end
        for (int i = 0; i < 9; i++) send(8'd1, 8'd1);
        in_valid = 1'b0;
        wait_sums(1);
        expv.push_back(9);
        compare_sums("midreset_sum", expv);
    endtask

    task automatic test_random();
        int expv[$];
        got.delete();
        rand_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            int a[$], b[$];
            for (int i = 0; i < 9; i++) begin
                a.push_back(int'($urandom_range(0, 255)));
                b.push_back(int'($urandom_range(0, 255)));
                send(8'(a[i]), 8'(b[i]));
            end
            expv.push_back(window_sum(a, b));
        end
        in_valid = 1'b0;
        wait_sums(4);
        rand_ready = 1'b0;
        out_ready = 1'b1;
        compare_sums("random_sum", expv);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
        in_valid4 = 1'b0; in_a4 = '0; in_b4 = '0; out_ready4 = 1'b1;
        test_reset();
        test_ones();
        test_max();
        test_back_to_back();
        test_stall();
        test_taps4();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
